// File: rtl/vend_disp_pkg.sv
// Shared types and message codes for the vending-machine display controller.
// Also holds the purchase decision, so every display block ranks faults the same way.
package vend_disp_pkg;

    localparam logic [2:0] MODE_NONE         = 3'd0;
    localparam logic [2:0] MODE_WELCOME      = 3'd1;
    localparam logic [2:0] MODE_INSUFFICIENT = 3'd2;
    localparam logic [2:0] MODE_SOLD_OUT     = 3'd3;
    localparam logic [2:0] MODE_NO_SELECT    = 3'd4;
    localparam logic [2:0] MODE_THANKS       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE,
        S_MSG
    } state_t;

    // MODE_NONE means the purchase may proceed; otherwise the highest-priority fault.
    function automatic logic [2:0] purchase_code(input logic sel_valid,
                                                 input logic sel_stock,
                                                 input logic short_money);
        if (!sel_valid)
            return MODE_NO_SELECT;
        else if (!sel_stock)
            return MODE_SOLD_OUT;
        else if (short_money)
            return MODE_INSUFFICIENT;
        else
            return MODE_NONE;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done pulses for the single cycle the count sits at 1,
// so a value of N loaded on state entry gives exactly N cycles in that state.
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/vend_display_controller.sv
// Chooses between the scrolling message and a money amount on the seven-segment
// display, runs the purchase decision and emits a one-cycle vend strobe.
module vend_display_controller
    import vend_disp_pkg::*;
#(
    parameter int NUM_ITEMS   = 5,
    parameter int MONEY_W     = 12,
    parameter int PRICE_W     = 8,
    parameter int MSG_HOLD    = 50_000_000,
    parameter int CHANGE_HOLD = 100_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_ITEMS-1:0] select,
    input  logic [NUM_ITEMS-1:0] stock,
    input  logic [MONEY_W-1:0]   moneyIn,
    input  logic [PRICE_W-1:0]   price,
    input  logic                 buy,
    output logic [2:0]           scrollMode,
    output logic                 showMoney,
    output logic [MONEY_W-1:0]   amountDisplay,
    output logic                 vend,
    output logic                 busy
);

    localparam int HOLD_MAX = (MSG_HOLD > CHANGE_HOLD) ? MSG_HOLD : CHANGE_HOLD;
    localparam int TIMER_W  = $clog2(HOLD_MAX + 1);

    state_t               state;
    logic                 buy_q;
    logic                 buy_rise;
    logic                 sel_valid;
    logic                 sel_stock;
    logic                 short_money;
    logic [2:0]           code;
    logic [MONEY_W-1:0]   price_ext;
    logic [MONEY_W-1:0]   change;
    logic [MONEY_W-1:0]   change_q;
    logic                 accept;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_value;
    logic                 tmr_done;

    assign buy_rise    = buy & ~buy_q;
    assign sel_valid   = $onehot(select);
    assign sel_stock   = |(select & stock);
    assign price_ext   = MONEY_W'(price);
    assign short_money = (moneyIn < price_ext);
    assign code        = purchase_code(sel_valid, sel_stock, short_money);
    assign change      = moneyIn - price_ext;
    assign accept      = ((state == S_IDLE) || (state == S_CREDIT)) && buy_rise;

    // The timer is loaded on the same edge that enters a timed state.
    assign tmr_load  = (accept && (code != MODE_NONE))
                     || (state == S_VEND)
                     || ((state == S_CHANGE) && tmr_done);
    assign tmr_value = (state == S_VEND) ? TIMER_W'(CHANGE_HOLD) : TIMER_W'(MSG_HOLD);

    hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            scrollMode    <= MODE_WELCOME;
            showMoney     <= 1'b0;
            amountDisplay <= '0;
            vend          <= 1'b0;
            busy          <= 1'b0;
            buy_q         <= 1'b0;
            change_q      <= '0;
        end else begin
            buy_q <= buy;
            vend  <= 1'b0;
            case (state)
                S_IDLE, S_CREDIT: begin
                    if (accept && (code != MODE_NONE)) begin
                        state      <= S_MSG;
                        scrollMode <= code;
                        showMoney  <= 1'b0;
                        busy       <= 1'b1;
                    end else if (accept) begin
                        // Credit stays frozen on screen during the strobe cycle.
                        state         <= S_VEND;
                        change_q      <= change;
                        vend          <= 1'b1;
                        busy          <= 1'b1;
                        showMoney     <= 1'b1;
                        amountDisplay <= moneyIn;
                    end else if (moneyIn != '0) begin
                        state         <= S_CREDIT;
                        scrollMode    <= MODE_WELCOME;
                        showMoney     <= 1'b1;
                        amountDisplay <= moneyIn;
                    end else begin
                        state         <= S_IDLE;
                        scrollMode    <= MODE_WELCOME;
                        showMoney     <= 1'b0;
                        amountDisplay <= '0;
                    end
                end
                S_VEND: begin
                    state         <= S_CHANGE;
                    showMoney     <= 1'b1;
                    amountDisplay <= change_q;
                end
                S_CHANGE: begin
                    if (tmr_done) begin
                        state      <= S_MSG;
                        scrollMode <= MODE_THANKS;
                        showMoney  <= 1'b0;
                    end
                end
                S_MSG: begin
                    if (tmr_done) begin
                        busy       <= 1'b0;
                        scrollMode <= MODE_WELCOME;
                        if (moneyIn != '0) begin
                            state         <= S_CREDIT;
                            showMoney     <= 1'b1;
                            amountDisplay <= moneyIn;
                        end else begin
                            state         <= S_IDLE;
                            showMoney     <= 1'b0;
                            amountDisplay <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_display_controller.sv
// Bench for vend_display_controller: a frame-script model predicts every output
// cycle, directed scenarios pin key values, then randomized traffic follows.
module tb_vend_display_controller;

    localparam int NI = 5;
    localparam int MW = 12;
    localparam int PW = 8;
    localparam int MH = 8;
    localparam int CH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] select = '0;
    logic [NI-1:0] stock = '1;
    logic [MW-1:0] moneyIn = '0;
    logic [PW-1:0] price = '0;
    logic          buy = 1'b0;
    logic [2:0]    scrollMode;
    logic          showMoney;
    logic [MW-1:0] amountDisplay;
    logic          vend;
    logic          busy;

    int asserts = 0;
    int failures = 0;

    vend_display_controller #(
        .NUM_ITEMS   (NI),
        .MONEY_W     (MW),
        .PRICE_W     (PW),
        .MSG_HOLD    (MH),
        .CHANGE_HOLD (CH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .select        (select),
        .stock         (stock),
        .moneyIn       (moneyIn),
        .price         (price),
        .buy           (buy),
        .scrollMode    (scrollMode),
        .showMoney     (showMoney),
        .amountDisplay (amountDisplay),
        .vend          (vend),
        .busy          (busy)
    );

    always #10 clock = ~clock;

    task automatic chk(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---- behavioural model: what the display must show after each edge ----
    typedef struct {
        int mode;
        int show;
        int amt;
        int vend;
        int busy;
    } frame_t;

    frame_t cur;
    frame_t script[$];
    bit     model_ready = 0;
    bit     m_prev_buy = 0;

    function automatic frame_t mk(input int mode, input int show, input int amt,
                                  input int v, input int b);
        frame_t f;
        f.mode = mode; f.show = show; f.amt = amt; f.vend = v; f.busy = b;
        return f;
    endfunction

    function automatic frame_t idle_frame(input int money);
        return mk(1, (money != 0) ? 1 : 0, money, 0, 0);
    endfunction

    task automatic push_msg(input int code);
        for (int k = 0; k < MH; k++) script.push_back(mk(code, 0, 0, 0, 1));
    endtask

    task automatic plan_purchase();
        int ones;
        int money;
        int cost;
        ones = 0;
        for (int k = 0; k < NI; k++) if (select[k]) ones++;
        money = int'(moneyIn);
        cost  = int'(price);
        if (ones != 1)                push_msg(4);
        else if ((select & stock) == 0) push_msg(3);
        else if (money < cost)        push_msg(2);
        else begin
            script.push_back(mk(1, 1, money, 1, 1));
            for (int k = 0; k < CH; k++) script.push_back(mk(1, 1, money - cost, 0, 1));
            push_msg(5);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            script.delete();
            m_prev_buy  = 0;
            cur         = mk(1, 0, 0, 0, 0);
            model_ready = 1;
        end else if (model_ready) begin
            bit rise;
            rise = buy && !m_prev_buy;
            m_prev_buy = buy;
            if (cur.busy != 0 && script.size() > 0) begin
                cur = script.pop_front();
            end else if (cur.busy == 0 && rise) begin
                plan_purchase();
                cur = script.pop_front();
            end else begin
                cur = idle_frame(int'(moneyIn));
            end
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            if (cur.show == 0) chk("scrollMode", int'(scrollMode), cur.mode);
            chk("showMoney", int'(showMoney), cur.show);
            if (cur.show != 0) chk("amountDisplay", int'(amountDisplay), cur.amt);
            chk("vend", int'(vend), cur.vend);
            chk("busy", int'(busy), cur.busy);
        end
    end

    // Watches a fixed window; buy is released after buy_hold edges (0 = untouched).
    task automatic watch(input int buy_hold, input int cycles, output int nbusy,
                         output int nvend, output int mode_first, output int amt2,
                         output int mode_last);
        nbusy = 0; nvend = 0; mode_first = 0; amt2 = -1; mode_last = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (i + 1 == buy_hold) buy = 1'b0;
            if (vend) nvend++;
            if (busy) begin
                nbusy++;
                if (nbusy == 1) mode_first = int'(scrollMode);
                if (nbusy == 2) amt2 = int'(amountDisplay);
                mode_last = int'(scrollMode);
            end
        end
    endtask

    initial begin
        int nb, nv, mf, a2, ml;

        // 1: reset and credit display
        repeat (2) @(negedge clock);
        chk("rst_scrollMode", int'(scrollMode), 1);
        chk("rst_showMoney", int'(showMoney), 0);
        chk("rst_vend", int'(vend), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        moneyIn = 12'd40;
        @(negedge clock);
        chk("credit_show", int'(showMoney), 1);
        chk("credit_amt", int'(amountDisplay), 40);

        // 2: invalid selections
        select = 5'b00000; buy = 1'b1;
        watch(1, 14, nb, nv, mf, a2, ml);
        chk("nosel0_mode", mf, 4);
        chk("nosel0_len", nb, MH);
        chk("nosel0_vend", nv, 0);
        chk("nosel0_back_amt", int'(amountDisplay), 40);
        select = 5'b00011; buy = 1'b1;
        watch(1, 14, nb, nv, mf, a2, ml);
        chk("nosel2_mode", mf, 4);
        chk("nosel2_len", nb, MH);

        // 3: sold out
        select = 5'b00100; stock = 5'b11011; moneyIn = 12'd100; price = 8'd100; buy = 1'b1;
        watch(1, 14, nb, nv, mf, a2, ml);
        chk("soldout_mode", mf, 3);
        chk("soldout_len", nb, MH);
        chk("soldout_vend", nv, 0);

        // 4: insufficient funds, buy held high
        select = 5'b00001; stock = 5'b11111; moneyIn = 12'd60; price = 8'd100; buy = 1'b1;
        watch(20, 30, nb, nv, mf, a2, ml);
        chk("insuf_mode", mf, 2);
        chk("insuf_len", nb, MH);
        chk("insuf_vend", nv, 0);

        // 5: successful vends
        moneyIn = 12'd150; buy = 1'b1;
        watch(1, 18, nb, nv, mf, a2, ml);
        chk("vend150_strobes", nv, 1);
        chk("vend150_change", a2, 50);
        chk("vend150_thanks", ml, 5);
        chk("vend150_len", nb, 1 + CH + MH);
        moneyIn = 12'd100; buy = 1'b1;
        watch(1, 18, nb, nv, mf, a2, ml);
        chk("vend100_strobes", nv, 1);
        chk("vend100_change", a2, 0);
        chk("vend100_len", nb, 1 + CH + MH);

        // 6: reset during CHANGE, then reset together with buy
        moneyIn = 12'd150; buy = 1'b1;
        @(negedge clock); buy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_mode", int'(scrollMode), 1);
        chk("midrst_show", int'(showMoney), 0);
        chk("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        watch(0, 20, nb, nv, mf, a2, ml);
        chk("midrst_novend", nv, 0);
        chk("midrst_nobusy", nb, 0);
        buy = 1'b1; reset = 1'b1;
        @(negedge clock);
        chk("rstbuy_vend", int'(vend), 0);
        chk("rstbuy_busy", int'(busy), 0);
        buy = 1'b0; reset = 1'b0;
        watch(0, 5, nb, nv, mf, a2, ml);
        chk("rstbuy_after", nv, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) buy = ~buy;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       moneyIn = '0;
                    1:       moneyIn = MW'(int'(price));
                    default: moneyIn = MW'($urandom_range(0, 400));
                endcase
            end
            if ($urandom_range(0, 7) == 0) price = PW'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 7))
                    0:       select = '0;
                    1:       select = NI'($urandom_range(0, 31));
                    default: select = NI'(1 << $urandom_range(0, NI - 1));
                endcase
            end
            if ($urandom_range(0, 9) == 0) stock = NI'($urandom_range(0, 31)) | NI'($urandom_range(0, 31));
        end
        reset = 1'b0;
        buy = 1'b0;
        repeat (30) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/vend_display_controller.md
Name: vend_display_controller

Overview:
Parametrised next-generation controller for the vending-machine seven-segment display. It decides what the display shows: a scrolling message code, or a numeric amount (credit or change). It takes the item-select vector, per-item stock flags, the inserted money, the selected item's price and the buy button. It computes change internally, holds timed messages for a programmable number of cycles, and issues a one-cycle vend strobe to the dispenser logic.

Parameters:
NUM_ITEMS, 5, number of products; width of select and stock vectors
MONEY_W, 12, width of moneyIn, amountDisplay and internal change
PRICE_W, 8, width of price (must be <= MONEY_W)
MSG_HOLD, 50_000_000, cycles an error or thank-you message is held (1 s at 50 MHz)
CHANGE_HOLD, 100_000_000, cycles the change amount is shown after a vend

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
select  in  NUM_ITEMS  one-hot item selection; all-zero means no selection
stock  in  NUM_ITEMS  per-item in-stock flag, 1 = available
moneyIn  in  MONEY_W  current inserted credit
price  in  PRICE_W  price of the currently selected item
buy  in  1  buy button, level; only its rising edge is acted on
scrollMode  out  3  message code (values defined in package)
showMoney  out  1  1 = display amountDisplay; 0 = display scrollMode message
amountDisplay  out  MONEY_W  amount to show when showMoney=1
vend  out  1  one-cycle strobe on a successful purchase
busy  out  1  1 while in VEND, CHANGE or MSG; buy edges are ignored while busy

Behaviour:
- One clock, clock; reset is synchronous and active-high, sampled only on the rising edge of clock. All outputs are registered.
- Reset values:
  - state=IDLE, scrollMode=MODE_WELCOME, showMoney=0, amountDisplay=0, vend=0, busy=0.
  - Timer=0, buy_q=0.
- Reset wins over every other simultaneous input. Reset mid-message or mid-vend returns to IDLE on the next edge, and no vend strobe is issued.
- buy_rise = buy & ~buy_q, where buy_q is buy registered. Holding buy high produces exactly one event.
- Selection is valid iff select is one-hot ($onehot). Zero or multiple bits set means invalid.
- sel_stock = |(select & stock).
- change = moneyIn - zero-extended price, computed at MONEY_W width. It is only used when moneyIn >= price, so it never wraps.
- States:
  - IDLE: scrollMode=WELCOME, showMoney=0. Go to CREDIT when moneyIn!=0. Evaluate buy_rise as in CREDIT.
  - CREDIT: showMoney=1, amountDisplay=moneyIn, tracked every cycle. Return to IDLE when moneyIn==0. On buy_rise, evaluate in this priority order:
    1. Invalid selection -> MSG with MODE_NO_SELECT.
    2. !sel_stock -> MSG with MODE_SOLD_OUT.
    3. moneyIn < price -> MSG with MODE_INSUFFICIENT.
    4. Otherwise -> VEND.
  - VEND: lasts one cycle. vend=1, the change value is latched, then go to CHANGE.
  - CHANGE: showMoney=1, amountDisplay=latched change, for CHANGE_HOLD cycles. Then MSG with MODE_THANKS.
  - MSG: showMoney=0, scrollMode=latched code, for MSG_HOLD cycles. Then go to CREDIT if moneyIn!=0, else IDLE.
- Latency: outputs reflect the decision one edge after the edge where buy_rise is sampled.
- Hold counts are exact. A message or change display is visible for exactly MSG_HOLD / CHANGE_HOLD clock cycles. The timer loads at state entry and counts down to 1.
- Inputs changing during VEND, CHANGE or MSG do not alter the displayed value.
- Price of 0 with a valid, stocked selection is a legal vend: change = moneyIn.
- moneyIn == price is a legal vend with change 0; CHANGE still shows 0 for CHANGE_HOLD cycles.
- Timer width = $clog2(max(MSG_HOLD, CHANGE_HOLD)+1).

Decomposition:
- Package vend_disp_pkg holds:
  - MODE_NONE=0, MODE_WELCOME=1, MODE_INSUFFICIENT=2, MODE_SOLD_OUT=3, MODE_NO_SELECT=4, MODE_THANKS=5 (3-bit).
  - State encoding S_IDLE, S_CREDIT, S_VEND, S_CHANGE, S_MSG.
- One sub-module: hold_timer. It is a parametrised down-counter with load, load value, and a one-cycle done output, sync reset. It is shared with future display blocks.

Test Plan:
(Bench uses MSG_HOLD=8, CHANGE_HOLD=4, NUM_ITEMS=5, 50 MHz clock.)
1. Reset 2 cycles, then idle -> scrollMode=1, showMoney=0, vend=0, busy=0; moneyIn=40 -> showMoney=1, amountDisplay=40.
2. Buy with select=0 and moneyIn=40 -> scrollMode=4, showMoney=0 for exactly 8 cycles, then CREDIT with amountDisplay=40. Repeat with select=5'b00011 -> same scrollMode=4.
3. select=5'b00100, stock=5'b11011, moneyIn=100, price=100, buy -> scrollMode=3 for 8 cycles, vend never asserted.
4. select=5'b00001, stock all 1, moneyIn=60, price=100, buy -> scrollMode=2; buy held high 20 cycles -> only one MSG sequence.
5. select=5'b00001, moneyIn=150, price=100, buy -> vend=1 for exactly one cycle; amountDisplay=50 with showMoney=1 for 4 cycles; then scrollMode=5 for 8 cycles. Repeat with moneyIn=100 -> amountDisplay=0.
6. Reset asserted during the CHANGE phase of scenario 5 -> next edge scrollMode=1, showMoney=0, busy=0, no further vend. Buy and reset in the same cycle -> reset wins, vend=0.
